// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, default widths, FSM states
// and the offset sign-extension helper.
package exec_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int OFF_W_DEF = 10;

    localparam logic [6:0] OP_ADD  = 7'h00;
    localparam logic [6:0] OP_SUB  = 7'h01;
    localparam logic [6:0] OP_MUL  = 7'h02;
    localparam logic [6:0] OP_LDW  = 7'h10;
    localparam logic [6:0] OP_STW  = 7'h11;
    localparam logic [6:0] OP_BEQ  = 7'h30;
    localparam logic [6:0] OP_JUMP = 7'h31;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    // Sign-extend the low 'width' bits of val to 64 bits; callers truncate to XLEN.
    function automatic logic signed [63:0] sext(input logic [63:0] val, input int width);
        logic signed [63:0] t;
        t = signed'(val << (64 - width));
        return t >>> (64 - width);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, XLEN cycles,
// low XLEN bits of a*b presented on product while done is high.
module seq_multiplier #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc_next;

    assign acc_next = mplier[0] ? acc + mcand : acc;
    // The final step's sum is forwarded combinationally so the caller can
    // register it on the same edge the multiplier goes idle.
    assign done     = busy && (cnt == CNT_W'(XLEN - 1));
    assign product  = acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start && !busy) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, multi-cycle MUL, address generation and branch resolution.
// Define EXEC_FORWARD_EN to bypass the previous ALU/MUL result into the operands.
module execute_stage
    import exec_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [6:0]       opcode,
    input  logic [4:0]       dst,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic [4:0]       src1_reg,
    input  logic [4:0]       src2_reg,
    input  logic [OFF_W-1:0] offsetlo,
    input  logic [XLEN-1:0]  pc_in,
    output logic             stall,
    output logic             ex_valid,
    output logic [6:0]       ex_opcode,
    output logic [4:0]       ex_dst,
    output logic [XLEN-1:0]  ex_result,
    output logic [XLEN-1:0]  ex_store_data,
    output logic             ex_write_reg,
    output logic             branch_taken,
    output logic [XLEN-1:0]  branch_target
);

    state_t          state, state_nxt;
    logic [XLEN-1:0] op_a, op_b, imm;
    logic [XLEN-1:0] alu_res, br_target;
    logic            alu_wr, br_taken, op_known;
    logic            mul_start, mul_busy, mul_done;
    logic [XLEN-1:0] mul_product;
    logic [4:0]      mul_dst;

    assign imm = XLEN'(sext(64'(offsetlo), OFF_W));

`ifdef EXEC_FORWARD_EN
    logic fwd_ok;
    assign fwd_ok = ex_valid && ex_write_reg &&
                    (ex_opcode == OP_ADD || ex_opcode == OP_SUB || ex_opcode == OP_MUL);
    assign op_a = (fwd_ok && ex_dst == src1_reg) ? ex_result : src1;
    assign op_b = (fwd_ok && ex_dst == src2_reg) ? ex_result : src2;
`else
    logic unused_src_regs;
    assign unused_src_regs = ^{src1_reg, src2_reg};
    assign op_a = src1;
    assign op_b = src2;
`endif

    assign mul_start = (state == IDLE) && in_valid && (opcode == OP_MUL);
    assign stall     = mul_busy;

    seq_multiplier #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (mul_start) state_nxt = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_res   = op_a + imm;
        alu_wr    = 1'b0;
        br_taken  = 1'b0;
        br_target = op_a + imm;
        op_known  = 1'b1;
        case (opcode)
            OP_ADD:  begin alu_res = op_a + op_b; alu_wr = 1'b1; end
            OP_SUB:  begin alu_res = op_a - op_b; alu_wr = 1'b1; end
            OP_LDW:  alu_wr = 1'b1;
            OP_STW:  alu_wr = 1'b0;
            OP_BEQ:  begin br_taken = (op_a == op_b); br_target = pc_in + imm; end
            OP_JUMP: br_taken = 1'b1;
            default: op_known = 1'b0;
        endcase
    end

    // Result register stage: valid and branch pulse default low every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mul_dst       <= '0;
            ex_valid      <= 1'b0;
            ex_opcode     <= '0;
            ex_dst        <= '0;
            ex_result     <= '0;
            ex_store_data <= '0;
            ex_write_reg  <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            state        <= state_nxt;
            ex_valid     <= 1'b0;
            branch_taken <= 1'b0;
            if (state == MUL_BUSY) begin
                if (mul_done) begin
                    ex_valid     <= 1'b1;
                    ex_opcode    <= OP_MUL;
                    ex_dst       <= mul_dst;
                    ex_result    <= mul_product;
                    ex_write_reg <= 1'b1;
                end
            end else if (in_valid) begin
                if (opcode == OP_MUL) begin
                    mul_dst <= dst;
                end else if (op_known) begin
                    ex_valid      <= 1'b1;
                    ex_opcode     <= opcode;
                    ex_dst        <= dst;
                    ex_result     <= alu_res;
                    ex_store_data <= op_b;
                    ex_write_reg  <= alu_wr;
                    branch_taken  <= br_taken;
                    branch_target <= br_target;
                end
            end
        end
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Third pipeline stage; sits directly downstream of the decode stage and consumes its registered outputs: opcode, dst, src1/src2 values, src1/src2 register indices and the 10-bit offset.
- Performs ALU ops, an iterative multi-cycle multiply, address generation and branch resolution.
- Registers results for the memory/writeback stages.
- Drives a stall back to decode/fetch while the multiplier is busy.

Parameters:
- XLEN, 32, datapath width; MUL takes XLEN iterations.
- OFF_W, 10, offset field width; sign-extended to XLEN.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  decode outputs hold a live instruction (decode enable delayed one cycle)
- opcode  in  7  from decode
- dst  in  5  destination register index
- src1, src2  in  XLEN  operand values read by decode
- src1_reg, src2_reg  in  5  operand register indices (forwarding compare)
- offsetlo  in  OFF_W  immediate/offset
- pc_in  in  XLEN  PC of the instruction at decode outputs
- stall  out  1  high while the multiplier is busy; upstream must hold its outputs
- ex_valid  out  1  result registers hold a completed instruction
- ex_opcode  out  7  opcode of the completed instruction
- ex_dst  out  5  destination register
- ex_result  out  XLEN  ALU/MUL result or memory address
- ex_store_data  out  XLEN  operand B, used by STW
- ex_write_reg  out  1  instruction writes the register file (ADD, SUB, MUL, LDW)
- branch_taken  out  1  one-cycle pulse on a taken BEQ/JUMP
- branch_target  out  XLEN  redirect PC, valid with branch_taken

Behaviour:
- Reset: all outputs 0, FSM in IDLE, MUL counter 0. Reset mid-MUL aborts the multiply with no result produced.
- Opcodes: ADD=7'h00, SUB=7'h01, MUL=7'h02, LDW=7'h10, STW=7'h11, BEQ=7'h30, JUMP=7'h31. Any other opcode is a NOP: ex_valid=0 the next cycle.
- Operands: A=src1, B=src2 (forwarding per Optional Feature); sext = sign-extended offsetlo.
- ADD: A+B. SUB: A-B. Both mod 2^XLEN with no flags.
- LDW/STW: ex_result = A+sext. STW: ex_store_data = B and ex_write_reg = 0.
- BEQ: taken iff A==B; branch_target = pc_in+sext; ex_write_reg = 0.
- JUMP: always taken; branch_target = A+sext.
- Latency, single-cycle ops: in_valid sampled at edge N in IDLE; outputs valid after edge N, for exactly one cycle. ex_valid drops the following cycle unless a new instruction is accepted.
- branch_taken is a one-cycle pulse aligned with ex_valid. Flushing younger instructions is upstream's job.
- FSM states: IDLE, MUL_BUSY.
- IDLE -> MUL_BUSY: on in_valid with opcode MUL. Latch A, B and dst; counter=0; ex_valid=0.
- MUL_BUSY: one shift-add step per cycle; stall=1; in_valid and all inputs ignored.
- MUL_BUSY -> IDLE: after step XLEN-1. ex_result = low XLEN bits of A*B, ex_valid=1, ex_write_reg=1; stall drops the same cycle.
- stall is a registered output that rises the cycle after MUL is accepted. The instruction decode latched alongside MUL acceptance stays held at decode outputs and is accepted in the first IDLE cycle.
- in_valid=0 in IDLE: ex_valid=0, other outputs hold their values.

Optional Feature:
- Macro: EXEC_FORWARD_EN.
- When defined: A = ex_result if (ex_valid && ex_write_reg && ex_opcode in {ADD,SUB,MUL} && ex_dst==src1_reg), else src1. B uses the same rule with src2_reg. Bypass from the immediately preceding result only.
- When undefined: A=src1, B=src2 always; software must insert NOPs to cover the hazard.

Decomposition:
- Package exec_pkg: opcode localparams, XLEN default, FSM state enum, and a sext function.
- One sub-module, seq_multiplier: start, a, b -> busy, done, product; iterative shift-add, XLEN cycles.

Test Plan:
- ADD: src1=11, src2=12, dst=3 -> next cycle ex_result=23, ex_write_reg=1, ex_dst=3, ex_valid=1 for one cycle.
- SUB: src1=10, src2=11 -> ex_result=32'hFFFF_FFFF. STW with src1=20, offsetlo=10'h3FF -> ex_result=19, ex_write_reg=0.
- MUL 7*6 then ADD held at decode -> stall high 32 cycles, ex_result=42 at completion, then ADD result on the following cycle.
- BEQ: src1=src2=5, pc_in=100, offsetlo=-4 -> branch_taken pulse, branch_target=96. Unequal operands -> no pulse.
- EXEC_FORWARD_EN: ADD r3=10+11, then ADD r4 with src1_reg=3 (stale src1=13) and src2=1 -> 22. With the macro undefined -> 14.
- Reset asserted at MUL iteration 15 -> stall=0, ex_valid=0 immediately; next ADD completes normally.
